// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connect4_pkg
// Description : Shared types and constants for the 4x4 Connect-4 game:
//               game state / player enums, the ten winning-line masks,
//               and active-low seven-segment glyph codes {a,b,c,d,e,f,g}.
// Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_TIE  = 2'd2
    } state_t;

    typedef enum logic {
        PL_P1 = 1'b0,
        PL_P2 = 1'b1
    } player_t;

    // Cell index = 4*row + col. Rows, then columns, then the two diagonals.
    localparam logic [9:0][15:0] WIN_MASKS = {
        16'h1248,   // anti-diagonal (r0c3 .. r3c0)
        16'h8421,   // main diagonal (r0c0 .. r3c3)
        16'h8888,   // column 3
        16'h4444,   // column 2
        16'h2222,   // column 1
        16'h1111,   // column 0
        16'hF000,   // row 3
        16'h0F00,   // row 2
        16'h00F0,   // row 1
        16'h000F    // row 0
    };

    // Seven-segment glyphs, bit order {a,b,c,d,e,f,g}, 0 = segment lit.
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_T     = 7'b1110000;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_EQ    = 7'b1110110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] player_glyph(input player_t p);
        return (p == PL_P1) ? SEG_1 : SEG_2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/connect4_win_check.sv
`default_nettype none
// ============================================================================
// Module      : connect4_win_check
// Description : Combinational line detector. Reports whether the mover owns
//               every cell of any of the ten lines and returns the union of
//               all completed lines as a cell mask.
// Ports       : i_occupancy [15:0] occupied cells
//               i_owner     [15:0] 1 = P1 owns the cell
//               i_mover            player who just moved
//               o_win              mover completed at least one line
//               o_win_mask  [15:0] cells belonging to completed lines
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_win_check
    import connect4_pkg::*;
(
    input  logic [15:0] i_occupancy,
    input  logic [15:0] i_owner,
    input  player_t     i_mover,
    output logic        o_win,
    output logic [15:0] o_win_mask
);

    logic [15:0] w_cells;
    logic [9:0]  w_hit;

    // Owner bit 0 means P2 only when the cell is occupied.
    assign w_cells = (i_mover == PL_P1) ? (i_occupancy & i_owner)
                                        : (i_occupancy & ~i_owner);

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_line
            assign w_hit[gi] = ((w_cells & WIN_MASKS[gi]) == WIN_MASKS[gi]);
        end
    endgenerate

    always_comb begin
        o_win_mask = '0;
        for (int i = 0; i < 10; i++) begin
            if (w_hit[i]) o_win_mask = o_win_mask | WIN_MASKS[i];
        end
    end

    assign o_win = |w_hit;

endmodule
`default_nettype wire

// File: rtl/connect4_top.sv
`default_nettype none
// ============================================================================
// Module      : connect4_top
// Description : Two-player Connect-4 on a 4x4 board. Captures a column on
//               the falling edge of BTN_EAST, synchronises the press into
//               clk, drops a piece, alternates turns and detects win / tie.
//               Drives LED column banks, debug buses and a 3-digit
//               multiplexed seven-segment status display.
// Ports       : clk, reset (async active-low)
//               Switch_0..3 column select (active-low), BTN_EAST (active-low)
//               clock_pos divider MSB
//               P6/P7/P8/P9_leds columns 0..3 (bit 2r = P1, 2r+1 = P2)
//               gameboard, player_moves debug buses
//               a..g, h cathodes (active-low), e1..e3 digit enables (low)
// Options     : CONNECT4_WIN_BLINK_EN - blink winning cells with clock_pos
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_top
    import connect4_pkg::*;
#(
    parameter int DIV_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Switch_0,
    input  logic        Switch_1,
    input  logic        Switch_2,
    input  logic        Switch_3,
    input  logic        BTN_EAST,
    output logic        clock_pos,
    output logic [7:0]  P6_leds,
    output logic [7:0]  P7_leds,
    output logic [7:0]  P8_leds,
    output logic [7:0]  P9_leds,
    output logic [15:0] gameboard,
    output logic [15:0] player_moves,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        h,
    output logic        e1,
    output logic        e2,
    output logic        e3
);

    // ------------------------------------------------------------------
    // Press capture in the button domain
    // ------------------------------------------------------------------
    logic [3:0] r_col_req;
    logic       r_press_tgl;

    always_ff @(negedge BTN_EAST or negedge reset) begin
        if (!reset) begin
            r_col_req   <= 4'hF;
            r_press_tgl <= 1'b0;
        end else begin
            r_col_req   <= {Switch_3, Switch_2, Switch_1, Switch_0};
            r_press_tgl <= ~r_press_tgl;
        end
    end

    // Toggle crosses into clk; r_col_req is stable long before the pulse.
    logic r_sync1, r_sync2, r_sync_prev;
    logic w_commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync1     <= r_press_tgl;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_commit = r_sync2 ^ r_sync_prev;

    // ------------------------------------------------------------------
    // Column decode: exactly one switch low
    // ------------------------------------------------------------------
    logic [1:0] w_col;
    logic       w_col_valid;

    always_comb begin
        w_col       = 2'd0;
        w_col_valid = 1'b1;
        case (~r_col_req)
            4'b0001: w_col = 2'd0;
            4'b0010: w_col = 2'd1;
            4'b0100: w_col = 2'd2;
            4'b1000: w_col = 2'd3;
            default: w_col_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t      r_state, w_state_next;
    player_t     r_turn, w_turn_next;
    player_t     r_winner, w_winner_next;
    logic [15:0] r_board, w_board_next;
    logic [15:0] r_owner, w_owner_next;
    logic [1:0]  w_row;
    logic        w_col_free;
    logic [15:0] w_cand_board, w_cand_owner, w_cell_bit;
    logic        w_win;
    logic [15:0] w_win_mask;

    // Lowest empty row: scanning top-down leaves the bottom-most hit.
    always_comb begin
        w_row      = 2'd0;
        w_col_free = 1'b0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_board[{r[1:0], w_col}]) begin
                w_col_free = 1'b1;
                w_row      = r[1:0];
            end
        end
    end

    assign w_cell_bit   = 16'h0001 << {w_row, w_col};
    assign w_cand_board = r_board | w_cell_bit;
    assign w_cand_owner = (r_turn == PL_P1) ? (r_owner | w_cell_bit) : r_owner;

    connect4_win_check u_win_check (
        .i_occupancy (w_cand_board),
        .i_owner     (w_cand_owner),
        .i_mover     (r_turn),
        .o_win       (w_win),
        .o_win_mask  (w_win_mask)
    );

    always_comb begin
        w_state_next  = r_state;
        w_turn_next   = r_turn;
        w_winner_next = r_winner;
        w_board_next  = r_board;
        w_owner_next  = r_owner;
        case (r_state)
            ST_PLAY: begin
                if (w_commit && w_col_valid && w_col_free) begin
                    w_board_next = w_cand_board;
                    w_owner_next = w_cand_owner;
                    w_turn_next  = (r_turn == PL_P1) ? PL_P2 : PL_P1;
                    if (w_win) begin
                        w_state_next  = ST_WIN;
                        w_winner_next = r_turn;
                    end else if (w_cand_board == 16'hFFFF) begin
                        w_state_next = ST_TIE;
                    end
                end
            end
            default: ;  // WIN / TIE hold until reset
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_PLAY;
            r_turn   <= PL_P1;
            r_winner <= PL_P1;
            r_board  <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_turn   <= w_turn_next;
            r_winner <= w_winner_next;
            r_board  <= w_board_next;
            r_owner  <= w_owner_next;
        end
    end

    // ------------------------------------------------------------------
    // Divider and digit scan
    // ------------------------------------------------------------------
    logic [DIV_BITS-1:0] r_div;
    logic                r_pos_prev;
    logic [1:0]          r_scan;
    logic [6:0]          r_seg, w_seg;
    logic [2:0]          r_en;

    assign clock_pos = r_div[DIV_BITS-1];

    always_comb begin
        w_seg = SEG_BLANK;
        case (r_scan)
            2'd0: w_seg = (r_state == ST_TIE) ? SEG_T : SEG_P;
            2'd1: begin
                if (r_state == ST_TIE)      w_seg = SEG_I;
                else if (r_state == ST_WIN) w_seg = player_glyph(r_winner);
                else                        w_seg = player_glyph(r_turn);
            end
            2'd2: begin
                if (r_state == ST_TIE)      w_seg = SEG_E;
                else if (r_state == ST_WIN) w_seg = SEG_EQ;
                else                        w_seg = SEG_BLANK;
            end
            default: w_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_pos_prev <= 1'b0;
            r_scan     <= 2'd0;
            r_seg      <= SEG_BLANK;
            r_en       <= 3'b111;
        end else begin
            r_div      <= r_div + DIV_BITS'(1);
            r_pos_prev <= r_div[DIV_BITS-1];
            if (r_div[DIV_BITS-1] && !r_pos_prev) begin
                r_scan <= (r_scan == 2'd2) ? 2'd0 : r_scan + 2'd1;
            end
            // Segments and enable registered together so they never skew.
            r_seg <= w_seg;
            r_en  <= ~(3'b001 << r_scan);
        end
    end

    assign {a, b, c, d, e, f, g} = r_seg;
    assign h  = 1'b1;
    assign e1 = r_en[0];
    assign e2 = r_en[1];
    assign e3 = r_en[2];

    // ------------------------------------------------------------------
    // LED banks
    // ------------------------------------------------------------------
    logic [15:0] w_blink_off;

`ifdef CONNECT4_WIN_BLINK_EN
    logic [15:0] r_win_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_mask <= '0;
        end else if (r_state == ST_PLAY && w_state_next == ST_WIN) begin
            r_win_mask <= w_win_mask;
        end
    end

    assign w_blink_off = (r_state == ST_WIN && !clock_pos) ? r_win_mask : '0;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^w_win_mask;
    assign w_blink_off   = '0;
`endif

    logic [15:0]     w_lit;
    logic [3:0][7:0] w_led;

    assign w_lit = r_board & ~w_blink_off;

    always_comb begin
        w_led = '0;
        for (int cc = 0; cc < 4; cc++) begin
            for (int rr = 0; rr < 4; rr++) begin
                w_led[cc][2*rr]   = w_lit[4*rr+cc] &  r_owner[4*rr+cc];
                w_led[cc][2*rr+1] = w_lit[4*rr+cc] & ~r_owner[4*rr+cc];
            end
        end
    end

    assign P6_leds      = w_led[0];
    assign P7_leds      = w_led[1];
    assign P8_leds      = w_led[2];
    assign P9_leds      = w_led[3];
    assign gameboard    = r_board;
    assign player_moves = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_connect4_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect4_top
// Description : Directed self-checking bench for connect4_top: three full
//               games (column win, diagonal win, tie), ignored moves after
//               a win, full column, invalid switch pattern, short press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect4_top;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Switch_0 = 1'b1, Switch_1 = 1'b1, Switch_2 = 1'b1, Switch_3 = 1'b1;
    logic        BTN_EAST = 1'b1;
    logic        clock_pos;
    logic [7:0]  P6_leds, P7_leds, P8_leds, P9_leds;
    logic [15:0] gameboard, player_moves;
    logic        a, b, c, d, e, f, g, h, e1, e2, e3;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G_P     = 7'b0011000;
    localparam logic [6:0] G_1     = 7'b1001111;
    localparam logic [6:0] G_2     = 7'b0010010;
    localparam logic [6:0] G_T     = 7'b1110000;
    localparam logic [6:0] G_I     = 7'b1111001;
    localparam logic [6:0] G_E     = 7'b0110000;
    localparam logic [6:0] G_EQ    = 7'b1110110;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    connect4_top #(.DIV_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .Switch_0(Switch_0), .Switch_1(Switch_1), .Switch_2(Switch_2), .Switch_3(Switch_3),
        .BTN_EAST(BTN_EAST), .clock_pos(clock_pos),
        .P6_leds(P6_leds), .P7_leds(P7_leds), .P8_leds(P8_leds), .P9_leds(P9_leds),
        .gameboard(gameboard), .player_moves(player_moves),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .e1(e1), .e2(e2), .e3(e3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_sw(input int col);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << col);
    endfunction

    task automatic press_raw(input logic [3:0] sw);
        {Switch_3, Switch_2, Switch_1, Switch_0} = sw;
        @(negedge clk);
        BTN_EAST = 1'b0;
        #7;
        BTN_EAST = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #20;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for each digit enable in scan order and checks its glyph.
    task automatic check_disp(input string tag, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2);
        logic [6:0] exp_seg [3];
        logic [2:0] want;
        logic       found;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        for (int k = 0; k < 3; k++) begin
            want  = ~(3'b001 << k);
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if ({e3, e2, e1} === want) found = 1'b1;
            end
            check($sformatf("%s_en%0d", tag, k), {31'd0, found}, 32'd1);
            check($sformatf("%s_dig%0d", tag, k), {25'd0, a, b, c, d, e, f, g},
                  {25'd0, exp_seg[k]});
        end
    endtask

    initial begin
        int game1 [7]  = '{0, 1, 0, 2, 0, 2, 0};
        int game2 [10] = '{1, 0, 2, 1, 2, 2, 3, 3, 3, 3};
        int game3 [16] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 0, 2, 1, 3};

        // Reset state while reset is held
        repeat (3) @(negedge clk);
        check("rst_board", {16'd0, gameboard}, 32'h0);
        check("rst_owner", {16'd0, player_moves}, 32'h0);
        check("rst_leds", {P6_leds, P7_leds, P8_leds, P9_leds}, 32'h0);
        check("rst_seg", {24'd0, a, b, c, d, e, f, g, h}, 32'hFF);
        check("rst_en", {29'd0, e3, e2, e1}, 32'h7);
        check("rst_clkpos", {31'd0, clock_pos}, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_disp("idle", G_P, G_1, G_BLANK);

        // Game 1: P1 wins on column 0
        foreach (game1[i]) press_raw(col_sw(game1[i]));
        check("g1_board", {16'd0, gameboard}, 32'h1157);
        check("g1_owner", {16'd0, player_moves}, 32'h1111);
        check("g1_p6", {24'd0, P6_leds}, 32'h55);
        check_disp("g1", G_P, G_1, G_EQ);

        // Commit after a win is ignored
        press_raw(col_sw(3));
        check("g1_post_board", {16'd0, gameboard}, 32'h1157);

        // Game 2: P2 main-diagonal win
        do_reset();
        check("g2_rst_board", {16'd0, gameboard}, 32'h0);
        foreach (game2[i]) press_raw(col_sw(game2[i]));
        check("g2_board", {16'd0, gameboard}, 32'h8CEF);
        check("g2_owner", {16'd0, player_moves}, 32'h084E);
        check("g2_p9", {24'd0, P9_leds}, 32'h99);
        check_disp("g2", G_P, G_2, G_EQ);

        // Game 3: full board, no line
        do_reset();
        foreach (game3[i]) press_raw(col_sw(game3[i]));
        check("g3_board", {16'd0, gameboard}, 32'hFFFF);
        check("g3_owner", {16'd0, player_moves}, 32'h35A5);
        check("g3_p6", {24'd0, P6_leds}, 32'h59);
        check("g3_p7", {24'd0, P7_leds}, 32'h66);
        check_disp("g3", G_T, G_I, G_E);

        // Full column, then one more press on it
        do_reset();
        for (int i = 0; i < 4; i++) press_raw(col_sw(0));
        check("fill_board", {16'd0, gameboard}, 32'h1111);
        check("fill_owner", {16'd0, player_moves}, 32'h0101);
        press_raw(col_sw(0));
        check("full_board", {16'd0, gameboard}, 32'h1111);
        check_disp("full", G_P, G_1, G_BLANK);

        // Two switches low -> ignored
        press_raw(4'b1100);
        check("inv_board", {16'd0, gameboard}, 32'h1111);
        check_disp("inv", G_P, G_1, G_BLANK);

        // 5 ns pulse aligned to a rising clk edge commits exactly one move
        {Switch_3, Switch_2, Switch_1, Switch_0} = col_sw(1);
        @(posedge clk);
        BTN_EAST = 1'b0;
        #5;
        BTN_EAST = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("short_board", {16'd0, gameboard}, 32'h1113);
        check("short_owner", {16'd0, player_moves}, 32'h0103);
        check_disp("short", G_P, G_2, G_BLANK);

        // Mid-game reset clears immediately
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_board", {16'd0, gameboard}, 32'h0);
        #19;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_disp("mid_rst", G_P, G_1, G_BLANK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
